// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/addbit.sv
// Gate-level 1-bit full adder; the only arithmetic element on the serial data path.
module addbit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (sum, ab_x, ci);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, ci);
    or  g_o0 (co, ab_a, cx_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder walks A/B LSB-first over WIDTH cycles,
// then publishes result, carry-out and signed overflow together.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] sh_next;

    addbit u_addbit (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .ci  (c_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sh_w1
            assign sh_next = fa_sum;
        end else begin : g_sh_wn
            assign sh_next = {fa_sum, sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_co;
                sh_d  = sh_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // c_q here is the carry into the MSB position.
                    state_d  = DONE;
                    result_d = sh_next;
                    cout_d   = fa_co;
                    ovf_d    = fa_co ^ c_q;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = opa;
                    b_d     = opb;
                    c_d     = cin;
                    sh_d    = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
